// File: rtl/mem_arb_pkg.sv
// Shared types for the unified CPU/DMA memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles the DMA port has been kept waiting;
// starved_o forces the next IDLE grant to go to the DMA port.
module arb_starve_ctr #(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic             starved_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved_o = (cnt_q == CNT_MAX);
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single instruction/data memory port between the CPU and a DMA
// port, sequencing each access over a fixed-latency memory (IDLE -> BUSY -> RESP).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ready,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LAT_W  = $clog2(MEM_LAT + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

    logic              starved;
    logic              dma_win;
    logic              dma_grant;
    logic              dma_in_service;
    logic [WAIT_W-1:0] wait_cnt;

    // DMA only wins with a live request: a stale saturated count must not grant an idle port.
    assign dma_win        = dma_req && (!cpu_req || starved);
    assign dma_grant      = (state_q == ARB_IDLE) && dma_win;
    assign dma_in_service = (state_q != ARB_IDLE) && (owner_q == OWN_DMA);

    arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (WAIT_W)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (dma_req && !dma_in_service),
        .clr_i     (!dma_req || dma_grant),
        .starved_o (starved),
        .cnt_o     (wait_cnt)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_d       = lat_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (cpu_req || dma_req) begin
                    state_d = ARB_BUSY;
                    lat_d   = '0;
                    owner_d = dma_win ? OWN_DMA : OWN_CPU;
                    we_d    = dma_win ? dma_we    : cpu_we;
                    addr_d  = dma_win ? dma_addr  : cpu_addr;
                    wdata_d = dma_win ? dma_wdata : cpu_wdata;
                end
            end
            ARB_BUSY: begin
                if (lat_q == LAT_LAST) begin
                    state_d = ARB_RESP;
                    if (!we_q) begin
                        if (owner_q == OWN_DMA) begin
                            dma_rdata_d = mem_rdata;
                        end else begin
                            cpu_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_CPU;
            lat_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lat_q       <= lat_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Strobes decode from registered state so an asynchronous reset drops them at once.
    assign mem_en    = (state_q == ARB_BUSY) && (lat_q == '0);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ready = (state_q == ARB_RESP) && (owner_q == OWN_CPU);
    assign dma_ready = (state_q == ARB_RESP) && (owner_q == OWN_DMA);
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run checked against a transaction-timeline reference model.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int MAXW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          cpu_req, cpu_we, cpu_ready;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_ready;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic          c1_req, c1_ready, d1_ready, m1_en, m1_we;
    logic [AW-1:0] c1_addr, m1_addr;
    logic [DW-1:0] c1_rdata, d1_rdata, m1_wdata, m1_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_WAIT(MAXW)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ready(dma_ready), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .MAX_WAIT(MAXW)) u_dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(c1_req), .cpu_we(1'b0), .cpu_addr(c1_addr), .cpu_wdata('0),
        .cpu_ready(c1_ready), .cpu_rdata(c1_rdata),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr('0), .dma_wdata('0),
        .dma_ready(d1_ready), .dma_rdata(d1_rdata),
        .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
        .mem_rdata(m1_rdata)
    );

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // A MEM_LAT=1 memory presents data in the same cycle as the strobe.
    assign m1_rdata = m1_en ? pattern(m1_addr) : 32'hBAD0_BAD0;

    int checks   = 0;
    int failures = 0;

    // Reference model: one transaction timeline anchored at grant cycle g.
    logic [DW-1:0] memory [logic [AW-1:0]];
    int            t, g, m_wait;
    bit            m_dma, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_cpu_rd, m_dma_rd;

    function automatic logic [DW-1:0] mem_of(input logic [AW-1:0] a);
        if (memory.exists(a)) return memory[a];
        return pattern(a);
    endfunction

    task automatic model_reset();
        t = 0; g = -100; m_wait = 0; m_dma = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_dma_rd = '0;
    endtask

    // Presents mem_rdata for the current cycle, advances the model, steps one clock.
    task automatic drive_cycle();
        int ph;
        bit idle, grant, dwin, serviced;
        ph = t - g;
        mem_rdata = (ph == LAT) ? mem_of(m_addr) : $urandom;
        if (ph == LAT) begin
            if (m_we) memory[m_addr] = m_wdata;
            else if (m_dma) m_dma_rd = mem_of(m_addr);
            else m_cpu_rd = mem_of(m_addr);
        end
        idle     = (ph >= LAT + 2);
        dwin     = dma_req && (!cpu_req || m_wait == MAXW);
        grant    = idle && (cpu_req || dma_req);
        serviced = !idle && m_dma;
        if (!dma_req || (grant && dwin)) m_wait = 0;
        else if (!serviced && m_wait < MAXW) m_wait++;
        if (grant) begin
            g = t; m_dma = dwin;
            m_we    = dwin ? dma_we    : cpu_we;
            m_addr  = dwin ? dma_addr  : cpu_addr;
            m_wdata = dwin ? dma_wdata : cpu_wdata;
        end
        t++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        c1_req = 0; c1_addr = '0; mem_rdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 0;
        clear_inputs();
        @(negedge clk);
        reset = 1;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 0;
        clear_inputs();
        #2;
        checks++;
        if ({mem_en, mem_we, cpu_ready, dma_ready} !== 4'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=0000", {mem_en, mem_we, cpu_ready, dma_ready});
        end
        checks++;
        if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h/%h exp=0", mem_addr, mem_wdata, cpu_rdata, dma_rdata);
        end
        checks++;
        if (u_dut.wait_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_wait got=%0d exp=0", u_dut.wait_cnt);
        end
        @(negedge clk);
        reset = 1;
        model_reset();
    endtask

    task automatic test_cpu_read();
        apply_reset();
        memory[32'h40] = 32'hDEAD_BEEF;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        for (int c = 1; c <= 5; c++) begin
            drive_cycle();
            checks++;
            if (mem_en !== (c == 1)) begin
                failures++;
                $display("FAIL cpu_read_mem_en c%0d got=%b exp=%b", c, mem_en, c == 1);
            end
            checks++;
            if ({cpu_ready, dma_ready} !== {c == 3, 1'b0}) begin
                failures++;
                $display("FAIL cpu_read_ready c%0d got=%b%b exp=%b0", c, cpu_ready, dma_ready, c == 3);
            end
            if (c == 3) begin
                checks++;
                if (cpu_rdata !== 32'hDEAD_BEEF) begin
                    failures++;
                    $display("FAIL cpu_read_rdata got=%h exp=deadbeef", cpu_rdata);
                end
            end
            if (cpu_ready) cpu_req = 0;
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        dma_req = 1; dma_we = 1; dma_addr = 32'h80; dma_wdata = 32'h1234;
        for (int c = 1; c <= 8; c++) begin
            drive_cycle();
            checks++;
            if ({mem_en, cpu_ready, dma_ready} !== {(c == 1 || c == 5), c == 3, c == 7}) begin
                failures++;
                $display("FAIL simul_strobes c%0d got=%b%b%b exp=%b%b%b", c, mem_en, cpu_ready, dma_ready,
                         (c == 1 || c == 5), c == 3, c == 7);
            end
            if (c == 5) begin
                checks++;
                if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h80, 32'h1234}) begin
                    failures++;
                    $display("FAIL simul_dma_fields got=%b/%h/%h exp=1/80/1234", mem_we, mem_addr, mem_wdata);
                end
            end
            if (cpu_ready) cpu_req = 0;
            if (dma_ready) dma_req = 0;
        end
    endtask

    task automatic test_starvation();
        apply_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
        dma_req = 1; dma_we = 0; dma_addr = 32'h200;
        for (int c = 1; c <= 12; c++) begin
            drive_cycle();
            checks++;
            if ({mem_en, cpu_ready, dma_ready} !== {(c == 1 || c == 5 || c == 9), (c == 3 || c == 7), c == 11}) begin
                failures++;
                $display("FAIL starve_strobes c%0d got=%b%b%b", c, mem_en, cpu_ready, dma_ready);
            end
            checks++;
            if (u_dut.wait_cnt !== 4'(m_wait)) begin
                failures++;
                $display("FAIL starve_wait c%0d got=%0d exp=%0d", c, u_dut.wait_cnt, m_wait);
            end
            if (c == 8 || c == 9) begin
                checks++;
                if (u_dut.wait_cnt !== ((c == 8) ? 4'd8 : 4'd0)) begin
                    failures++;
                    $display("FAIL starve_wait_edge c%0d got=%0d exp=%0d", c, u_dut.wait_cnt, (c == 8) ? 8 : 0);
                end
            end
            if (c == 9) begin
                checks++;
                if (mem_addr !== 32'h200) begin
                    failures++;
                    $display("FAIL starve_dma_addr got=%h exp=200", mem_addr);
                end
            end
            if (dma_ready) dma_req = 0;
        end
    endtask

    task automatic test_req_drop();
        apply_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h44;
        for (int c = 1; c <= 8; c++) begin
            drive_cycle();
            cpu_req  = 0;
            checks++;
            if ({mem_en, cpu_ready, dma_ready} !== {c == 1, c == 3, 1'b0}) begin
                failures++;
                $display("FAIL drop_strobes c%0d got=%b%b%b exp=%b%b0", c, mem_en, cpu_ready, dma_ready, c == 1, c == 3);
            end
            if (c <= 2) begin
                checks++;
                if (mem_addr !== 32'h44) begin
                    failures++;
                    $display("FAIL drop_addr_held c%0d got=%h exp=44", c, mem_addr);
                end
            end
            if (c == 3) begin
                checks++;
                if (cpu_rdata !== pattern(32'h44)) begin
                    failures++;
                    $display("FAIL drop_rdata got=%h exp=%h", cpu_rdata, pattern(32'h44));
                end
            end
            cpu_addr = $urandom;
        end
    endtask

    task automatic test_reset_mid_busy();
        apply_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h300; cpu_wdata = 32'hCAFE;
        drive_cycle();
        drive_cycle();
        checks++;
        if (mem_addr !== 32'h300) begin
            failures++;
            $display("FAIL rst_mid_pre_addr got=%h exp=300", mem_addr);
        end
        reset = 0;
        #1;
        checks++;
        if ({mem_en, mem_we, cpu_ready, dma_ready, mem_addr, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%b%b%b%b/%h/%h exp=0", mem_en, mem_we, cpu_ready, dma_ready,
                     mem_addr, mem_wdata);
        end
        cpu_req = 0;
        @(negedge clk);
        reset = 1;
        model_reset();
        for (int c = 1; c <= 6; c++) begin
            drive_cycle();
            checks++;
            if ({mem_en, cpu_ready, dma_ready} !== 3'b000) begin
                failures++;
                $display("FAIL rst_mid_after c%0d got=%b%b%b exp=000", c, mem_en, cpu_ready, dma_ready);
            end
        end
    endtask

    task automatic test_lat1_back_to_back();
        logic prev_en;
        apply_reset();
        prev_en = 0;
        c1_req = 1; c1_addr = 32'h100;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (c1_ready !== (c == 2 || c == 5)) begin
                failures++;
                $display("FAIL lat1_ready c%0d got=%b exp=%b", c, c1_ready, (c == 2 || c == 5));
            end
            checks++;
            if ((m1_en & prev_en) !== 1'b0) begin
                failures++;
                $display("FAIL lat1_en_consecutive c%0d got=1 exp=0", c);
            end
            prev_en = m1_en;
            if (c == 2 || c == 5) begin
                checks++;
                if (c1_rdata !== pattern((c == 2) ? 32'h100 : 32'h104)) begin
                    failures++;
                    $display("FAIL lat1_rdata c%0d got=%h exp=%h", c, c1_rdata, pattern((c == 2) ? 32'h100 : 32'h104));
                end
            end
            if (c == 2) c1_addr = 32'h104;
            if (c == 5) c1_req = 0;
        end
    endtask

    task automatic test_random();
        int ph;
        bit busy, cpu_out, dma_out;
        apply_reset();
        cpu_out = 0; dma_out = 0;
        for (int i = 0; i < 800; i++) begin
            ph   = t - g;
            busy = (ph >= 1) && (ph <= LAT);
            checks++;
            if ({mem_en, cpu_ready, dma_ready} !== {ph == 1, (ph == LAT + 1) && !m_dma, (ph == LAT + 1) && m_dma}) begin
                failures++;
                $display("FAIL rnd_strobes cyc%0d got=%b%b%b exp=%b%b%b", i, mem_en, cpu_ready, dma_ready,
                         ph == 1, (ph == LAT + 1) && !m_dma, (ph == LAT + 1) && m_dma);
            end
            checks++;
            if ({cpu_rdata, dma_rdata} !== {m_cpu_rd, m_dma_rd}) begin
                failures++;
                $display("FAIL rnd_rdata cyc%0d got=%h/%h exp=%h/%h", i, cpu_rdata, dma_rdata, m_cpu_rd, m_dma_rd);
            end
            checks++;
            if (u_dut.wait_cnt !== 4'(m_wait)) begin
                failures++;
                $display("FAIL rnd_wait cyc%0d got=%0d exp=%0d", i, u_dut.wait_cnt, m_wait);
            end
            if (busy) begin
                checks++;
                if ({mem_we, mem_addr, mem_wdata} !== {m_we, m_addr, m_wdata}) begin
                    failures++;
                    $display("FAIL rnd_mem_fields cyc%0d got=%b/%h/%h exp=%b/%h/%h", i, mem_we, mem_addr,
                             mem_wdata, m_we, m_addr, m_wdata);
                end
            end
            if (cpu_ready) begin cpu_out = 0; cpu_req = 0; end
            if (dma_ready) begin dma_out = 0; dma_req = 0; end
            if (!cpu_out && $urandom_range(0, 3) != 0) begin
                cpu_out = 1; cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = {24'h0, 8'($urandom)}; cpu_wdata = $urandom;
            end
            if (!dma_out && $urandom_range(0, 1) != 0) begin
                dma_out = 1; dma_req = 1; dma_we = 1'($urandom_range(0, 1));
                dma_addr = {24'h0, 8'($urandom)}; dma_wdata = $urandom;
            end
            drive_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_simultaneous();
        test_starvation();
        test_req_drop();
        test_reset_mid_busy();
        test_random();
        test_lat1_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
